// File: rtl/alarm_pkg.sv
// Shared types and default parameters for the alarm responder.
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_e;

  localparam int unsigned DEF_SNOOZE_SECONDS = 8;
  localparam int unsigned DEF_RING_TIMEOUT   = 30;
  localparam int unsigned DEF_MAX_SNOOZE     = 3;

endpackage

// File: rtl/alarm_responder_if.sv
// Control inputs and status outputs of the alarm responder.
// The master side drives the controls, the slave side is the responder.
interface alarm_responder_if;

  logic       ena;
  logic       alarm;
  logic       sec_tick;
  logic       snooze_btn;
  logic       dismiss_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;
  logic       timeout;

  modport master (
    output ena, alarm, sec_tick, snooze_btn, dismiss_btn,
    input  buzzer, ringing, snoozing, snooze_cnt, timeout
  );

  modport slave (
    input  ena, alarm, sec_tick, snooze_btn, dismiss_btn,
    output buzzer, ringing, snoozing, snooze_cnt, timeout
  );

endinterface

// File: rtl/alarm_responder_edge_detect.sv
// Rising-edge detector against a registered copy of the input.
// The copy only updates while ena is high, so a frozen block sees no edges.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Registered copy of the input level, held while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else if (ena) begin
      d_q <= d;
    end
  end

  assign rise = ena & d & ~d_q;

endmodule

// File: rtl/alarm_responder.sv
// Alarm responder: rings on an alarm edge, supports limited snoozes,
// dismiss, and an auto-stop timeout after unanswered ringing.
// Optional macro ALARM_RESPONDER_BEEP_EN makes the buzzer toggle on each
// second while ringing; without it the buzzer is steady during ringing.
module alarm_responder
  import alarm_pkg::*;
#(
  parameter int unsigned SNOOZE_SECONDS = DEF_SNOOZE_SECONDS,
  parameter int unsigned RING_TIMEOUT   = DEF_RING_TIMEOUT,
  parameter int unsigned MAX_SNOOZE     = DEF_MAX_SNOOZE
) (
  input logic              clk,
  input logic              rst_n,
  alarm_responder_if.slave bus
);

  localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_SECONDS);
  localparam logic [7:0] RING_LIMIT  = 8'(RING_TIMEOUT);
  localparam logic [1:0] SNOOZE_CAP  = 2'(MAX_SNOOZE);

  logic alarm_rise;
  logic snooze_rise;
  logic dismiss_rise;

  edge_detect u_alarm_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (bus.ena),
    .d    (bus.alarm),
    .rise (alarm_rise)
  );

  edge_detect u_snooze_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (bus.ena),
    .d    (bus.snooze_btn),
    .rise (snooze_rise)
  );

  edge_detect u_dismiss_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (bus.ena),
    .d    (bus.dismiss_btn),
    .rise (dismiss_rise)
  );

  alarm_state_e state;
  logic [7:0]   ring_cnt;
  logic [7:0]   snz_timer;
  logic [1:0]   snooze_cnt_q;
  logic         buzzer_q;
  logic         ringing_q;
  logic         snoozing_q;
  logic         timeout_q;
  logic [7:0]   ring_cnt_inc;

  assign ring_cnt_inc = ring_cnt + 8'd1;

  // State machine with all outputs registered alongside the state.
  // NOTE: non-blocking assignments keep every register reading the
  // pre-edge values, so the case arms below are order-independent.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the asynchronous reset clears every state register here so
    // an aborted event leaves no residue and no timeout pulse.
    if (!rst_n) begin
      state        <= ST_IDLE;
      ring_cnt     <= 8'd0;
      snz_timer    <= 8'd0;
      snooze_cnt_q <= 2'd0;
      buzzer_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snoozing_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (bus.ena) begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alarm_rise) begin
            state        <= ST_RINGING;
            ring_cnt     <= 8'd0;
            snooze_cnt_q <= 2'd0;
            buzzer_q     <= 1'b1;
            ringing_q    <= 1'b1;
          end
        end

        ST_RINGING: begin
          if (dismiss_rise) begin
            state     <= ST_IDLE;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
          end else if (snooze_rise && (snooze_cnt_q < SNOOZE_CAP)) begin
            state        <= ST_SNOOZE;
            snz_timer    <= SNOOZE_LOAD;
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
            buzzer_q     <= 1'b0;
            ringing_q    <= 1'b0;
            snoozing_q   <= 1'b1;
          end else if (bus.sec_tick) begin
            ring_cnt <= ring_cnt_inc;
            if (ring_cnt_inc == RING_LIMIT) begin
              state     <= ST_IDLE;
              timeout_q <= 1'b1;
              buzzer_q  <= 1'b0;
              ringing_q <= 1'b0;
            end else begin
`ifdef ALARM_RESPONDER_BEEP_EN
              buzzer_q <= ~buzzer_q;
`endif
            end
          end
        end

        ST_SNOOZE: begin
          if (dismiss_rise) begin
            state      <= ST_IDLE;
            snoozing_q <= 1'b0;
          end else if (bus.sec_tick) begin
            if (snz_timer == 8'd1) begin
              state      <= ST_RINGING;
              ring_cnt   <= 8'd0;
              snz_timer  <= 8'd0;
              buzzer_q   <= 1'b1;
              ringing_q  <= 1'b1;
              snoozing_q <= 1'b0;
            end else begin
              snz_timer <= snz_timer - 8'd1;
            end
          end
        end

        default: begin
          state      <= ST_IDLE;
          buzzer_q   <= 1'b0;
          ringing_q  <= 1'b0;
          snoozing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = ringing_q;
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snooze_cnt_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_alarm_responder.sv
// Scoreboard bench for alarm_responder: stimulus steps a behavioural model
// and queues the expected outputs; a monitor compares after each clock edge.
module tb_alarm_responder;

  localparam int SNZ  = 3;
  localparam int RT   = 4;
  localparam int MAXS = 2;
`ifdef ALARM_RESPONDER_BEEP_EN
  localparam bit BEEP = 1'b1;
`else
  localparam bit BEEP = 1'b0;
`endif

  typedef struct packed {
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_cnt;
    logic       timeout;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alarm_responder_if bus ();

  alarm_responder #(
    .SNOOZE_SECONDS(SNZ),
    .RING_TIMEOUT  (RT),
    .MAX_SNOOZE    (MAXS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  out_t exp_q[$];
  out_t mon_exp;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   tout_seen = 0;

  // Behavioural model: an alarm event is "ringing", "snoozing" or neither.
  bit m_ring, m_snz, m_buzz, m_tout;
  int m_secs_rung, m_secs_left, m_used;
  bit p_a, p_s, p_d;

  function automatic out_t cur_out();
    out_t o;
    o.buzzer     = bus.buzzer;
    o.ringing    = bus.ringing;
    o.snoozing   = bus.snoozing;
    o.snooze_cnt = bus.snooze_cnt;
    o.timeout    = bus.timeout;
    return o;
  endfunction

  function automatic out_t model_out();
    out_t o;
    o.buzzer     = m_buzz;
    o.ringing    = m_ring;
    o.snoozing   = m_snz;
    o.snooze_cnt = 2'(m_used);
    o.timeout    = m_tout;
    return o;
  endfunction

  task automatic model_reset();
    m_ring = 0; m_snz = 0; m_buzz = 0; m_tout = 0;
    m_secs_rung = 0; m_secs_left = 0; m_used = 0;
    p_a = 0; p_s = 0; p_d = 0;
  endtask

  task automatic model_step(input bit a, input bit s, input bit d,
                            input bit t, input bit e);
    bit ae, se, de;
    if (!e) return;
    ae = a & ~p_a; se = s & ~p_s; de = d & ~p_d;
    p_a = a; p_s = s; p_d = d;
    m_tout = 0;
    if (m_ring) begin
      if (de) begin
        m_ring = 0; m_buzz = 0;
      end else if (se && m_used < MAXS) begin
        m_ring = 0; m_snz = 1; m_buzz = 0;
        m_secs_left = SNZ; m_used++;
      end else if (t) begin
        m_secs_rung++;
        if (m_secs_rung == RT) begin
          m_ring = 0; m_buzz = 0; m_tout = 1;
        end else if (BEEP) begin
          m_buzz = ~m_buzz;
        end
      end
    end else if (m_snz) begin
      if (de) begin
        m_snz = 0;
      end else if (t) begin
        m_secs_left--;
        if (m_secs_left == 0) begin
          m_snz = 0; m_ring = 1; m_buzz = 1; m_secs_rung = 0;
        end
      end
    end else if (ae) begin
      m_ring = 1; m_buzz = 1; m_secs_rung = 0; m_used = 0;
    end
  endtask

  task automatic check(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got buz=%0b ring=%0b snz=%0b cnt=%0d to=%0b, need buz=%0b ring=%0b snz=%0b cnt=%0d to=%0b",
                  name, $time, act.buzzer, act.ringing, act.snoozing, act.snooze_cnt, act.timeout,
                  exp.buzzer, exp.ringing, exp.snoozing, exp.snooze_cnt, exp.timeout);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, need %0d", name, $time, act, exp);
  endtask

  // One clock of stimulus; the model's expectation is queued for the monitor.
  task automatic step(input bit a, input bit s, input bit d,
                      input bit t, input bit e);
    @(negedge clk);
    rst_n           = 1'b1;
    bus.alarm       = a;
    bus.snooze_btn  = s;
    bus.dismiss_btn = d;
    bus.sec_tick    = t;
    bus.ena         = e;
    model_step(a, s, d, t, e);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  task automatic ticks(input int n, input bit e);
    repeat (n) begin
      step(0, 0, 0, 1, e);
      step(0, 0, 0, 0, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.alarm       = 1'b0;
    bus.snooze_btn  = 1'b0;
    bus.dismiss_btn = 1'b0;
    bus.sec_tick    = 1'b0;
    bus.ena         = 1'b1;
    #1;
    check("async_reset", cur_out(), out_t'(0));
    model_reset();
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        check("cycle", cur_out(), mon_exp);
        if (bus.timeout) tout_seen++;
      end
    end
  end

  initial begin
    int base;
    int guard;
    bit la, ls, ld;
    bus.ena = 1'b1; bus.alarm = 1'b0; bus.sec_tick = 1'b0;
    bus.snooze_btn = 1'b0; bus.dismiss_btn = 1'b0;
    model_reset();
    #3;
    check("reset_state", cur_out(), out_t'(0));

    // Unanswered ringing times out after RT ticks.
    base = tout_seen;
    step(1, 0, 0, 0, 1);
    idle(1);
    ticks(RT, 1);
    idle(1);
    check_int("timeout_pulses", tout_seen - base, 1);

    // Snooze then return to ringing after SNZ ticks.
    step(1, 0, 0, 0, 1);
    idle(1);
    step(0, 1, 0, 0, 1);
    idle(1);
    ticks(SNZ, 1);
    // Second snooze reaches the cap, third is ignored.
    step(0, 1, 0, 0, 1);
    idle(1);
    ticks(SNZ, 1);
    step(0, 1, 0, 0, 1);
    idle(1);
    check_int("snooze_cap_cnt", int'(bus.snooze_cnt), MAXS);
    check_int("snooze_cap_ring", int'(bus.ringing), 1);
    step(0, 0, 1, 0, 1);
    idle(1);

    // Simultaneous snooze and dismiss: dismiss wins, count unchanged.
    step(1, 0, 0, 0, 1);
    idle(1);
    step(0, 1, 0, 0, 1);
    idle(1);
    ticks(SNZ, 1);
    step(0, 1, 1, 0, 1);
    idle(1);
    check_int("dismiss_wins_cnt", int'(bus.snooze_cnt), 1);

    // Freeze mid-snooze with ticks arriving while disabled.
    step(1, 0, 0, 0, 1);
    idle(1);
    step(0, 1, 0, 0, 1);
    idle(1);
    ticks(1, 1);
    ticks(10, 0);
    ticks(SNZ - 1, 1);
    step(0, 0, 1, 0, 1);
    idle(1);

    // Reset mid-ringing after a few beeps.
    step(1, 0, 0, 0, 1);
    idle(1);
    ticks(RT - 1, 1);
    do_reset();
    idle(2);

    // Randomised traffic.
    la = 0; ls = 0; ld = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        la = 0; ls = 0; ld = 0;
      end else begin
        if ($urandom_range(0, 7) == 0) la = ~la;
        if ($urandom_range(0, 5) == 0) ls = ~ls;
        if ($urandom_range(0, 19) == 0) ld = ~ld;
        step(la, ls, ld, $urandom_range(0, 2) == 0, $urandom_range(0, 15) != 0);
      end
    end
    step(0, 0, 0, 0, 1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check_int("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alarm_responder.md
ALARM_RESPONDER -- requirements
Module: alarm_responder

Interface
REQ-001 Parameter SNOOZE_SECONDS, default 8: snooze duration in seconds ticks, range 1..255.
REQ-002 Parameter RING_TIMEOUT, default 30: ticks of unanswered ringing before auto-stop, range 1..255.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event, range 1..3.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ena  input  1  when low, all registers hold their value.
REQ-007 alarm  input  1  alarm level from the clock block; a rising edge starts an alarm event.
REQ-008 sec_tick  input  1  one-cycle pulse per second.
REQ-009 snooze_btn  input  1  synchronous, debounced button level.
REQ-010 dismiss_btn  input  1  synchronous, debounced button level.
REQ-011 buzzer  output  1  registered buzzer drive.
REQ-012 ringing  output  1  high in state RINGING.
REQ-013 snoozing  output  1  high in state SNOOZE.
REQ-014 snooze_cnt  output  2  snoozes used in the current event.
REQ-015 timeout  output  1  one-cycle pulse when ringing auto-stops.

Function
REQ-016 The block SHALL implement the states IDLE, RINGING and SNOOZE, registered, with a one-cycle latency from the qualifying input to the state change.
REQ-017 The block SHALL detect rising edges of alarm, snooze_btn and dismiss_btn against registered copies; only edges act, so held levels SHALL NOT retrigger.
REQ-018 IDLE with an alarm edge SHALL go to RINGING, clear ring_cnt and clear snooze_cnt.
REQ-019 RINGING with a dismiss edge SHALL go to IDLE; dismiss SHALL win over a simultaneous snooze edge or timeout.
REQ-020 RINGING with a snooze edge while snooze_cnt<MAX_SNOOZE SHALL go to SNOOZE, load snz_timer=SNOOZE_SECONDS and increment snooze_cnt; the snooze edge SHALL be ignored when snooze_cnt==MAX_SNOOZE.
REQ-021 RINGING SHALL increment the 8-bit ring_cnt on each sec_tick; the tick that makes ring_cnt==RING_TIMEOUT SHALL go to IDLE and pulse timeout for one cycle.
REQ-022 SNOOZE SHALL decrement snz_timer on each sec_tick; the tick at snz_timer==1 SHALL return to RINGING with ring_cnt cleared.
REQ-023 SNOOZE with a dismiss edge SHALL go to IDLE.
REQ-024 Alarm edges SHALL be ignored outside IDLE.
REQ-025 snooze_cnt SHALL hold its value in IDLE until the next alarm edge.
REQ-026 buzzer SHALL be 0 in IDLE and in SNOOZE.
REQ-027 ena low SHALL freeze the state, all counters and the edge registers; edges arriving during ena low are lost.

Reset
REQ-028 On rst_n low, the block SHALL asynchronously force state=IDLE, all counters to 0, edge registers to 0 and buzzer, ringing, snoozing, snooze_cnt and timeout to 0.
REQ-029 Reset asserted mid-RINGING or mid-SNOOZE SHALL abort the event with no timeout pulse.

Configuration
REQ-030 With macro ALARM_RESPONDER_BEEP_EN defined, buzzer SHALL toggle on each sec_tick while in RINGING and SHALL start at 1 on entry to RINGING.
REQ-031 Without ALARM_RESPONDER_BEEP_EN defined, buzzer SHALL be a steady 1 throughout RINGING.

Structure
REQ-032 Shared package alarm_pkg SHALL hold the state enum type and the default SNOOZE_SECONDS, RING_TIMEOUT and MAX_SNOOZE constants.
REQ-033 Rising-edge detection SHALL be a sub-module named edge_detect, with clk, rst_n, ena, d inputs and a rise output, instantiated three times.

Verification (bench parameters SNOOZE_SECONDS=3, RING_TIMEOUT=4, MAX_SNOOZE=2)
REQ-034 Alarm edge, then 4 ticks -> ringing=1 one cycle after the edge; timeout pulses once on the 4th tick; state returns to IDLE.
REQ-035 Ring, snooze edge, 3 ticks -> snoozing=1 and snooze_cnt=1; ringing=1 again after the 3rd tick.
REQ-036 Ring, snooze, wait, snooze, wait, 3rd snooze -> snooze_cnt stops at 2; the 3rd snooze is ignored and ringing stays 1.
REQ-037 Snooze and dismiss edges in the same cycle while ringing -> IDLE, snooze_cnt unchanged.
REQ-038 ena=0 for 10 ticks mid-SNOOZE -> snz_timer and outputs frozen; after ena=1, exactly the remaining ticks elapse before ringing.
REQ-039 rst_n low mid-RINGING -> all outputs 0 immediately, with no timeout pulse; with ALARM_RESPONDER_BEEP_EN defined, buzzer reads 1,0,1,0 across successive ticks while ringing.
